// File: rtl/ysyx_23060180_lsu_pkg.sv
// Shared types and constants for the ysyx_23060180 load/store unit.
package ysyx_23060180_lsu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned FUNC3_W = 3;
    localparam int unsigned MASK_W  = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    localparam logic [FUNC3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNC3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNC3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNC3_W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    // Request fields that must survive past the acceptance cycle.
    typedef struct packed {
        logic               we;
        logic [FUNC3_W-1:0] func3;
        logic [1:0]         addr_lo;
        logic [RD_W-1:0]    rd;
    } lsu_lat_t;

endpackage

// File: rtl/ysyx_23060180_lsu_if.sv
// Execute-stage request/writeback interface and data-memory bus interface.
interface ysyx_23060180_lsu_req_if;
    import ysyx_23060180_lsu_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [FUNC3_W-1:0] req_func3;
    logic [XLEN-1:0]    req_addr;
    logic [XLEN-1:0]    req_wdata;
    logic [RD_W-1:0]    req_rd;
    logic               wb_valid;
    logic [RD_W-1:0]    wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               wb_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
        input  req_ready, wb_valid, wb_rd, wb_data, wb_err
    );
    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
        output req_ready, wb_valid, wb_rd, wb_data, wb_err
    );
endinterface

interface ysyx_23060180_lsu_mem_if;
    import ysyx_23060180_lsu_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060180_lsu_align.sv
// Byte-lane steering for stores, extract/extend for loads, and legality check.
module ysyx_23060180_lsu_align
    import ysyx_23060180_lsu_pkg::*;
(
    input  logic               we,
    input  logic [FUNC3_W-1:0] func3,
    input  logic [1:0]         addr_lo,
    input  logic [XLEN-1:0]    wdata,
    input  logic [XLEN-1:0]    rdata,
    output logic [XLEN-1:0]    st_wdata_c,
    output logic [MASK_W-1:0]  st_wmask_c,
    output logic [XLEN-1:0]    ld_data_c,
    output logic               bad_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        st_wdata_c = '0;
        st_wmask_c = '0;
        if (we) begin
            case (func3)
                F3_B: begin
                    st_wdata_c = {4{wdata[7:0]}};
                    st_wmask_c = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    st_wdata_c = {2{wdata[15:0]}};
                    st_wmask_c = 4'b0011 << addr_lo;
                end
                F3_W: begin
                    st_wdata_c = wdata;
                    st_wmask_c = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (func3)
            F3_B:    ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data_c = rdata;
            F3_BU:   ld_data_c = {24'h0, shifted[7:0]};
            F3_HU:   ld_data_c = {16'h0, shifted[15:0]};
            default: ld_data_c = '0;
        endcase
    end

    // Unsigned variants exist only for loads; everything else is illegal.
    always_comb begin
        case (func3)
            F3_B:    bad_c = 1'b0;
            F3_H:    bad_c = addr_lo[0];
            F3_W:    bad_c = (addr_lo != 2'b00);
            F3_BU:   bad_c = we;
            F3_HU:   bad_c = we | addr_lo[0];
            default: bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060180_lsu.sv
// Memory-stage load/store unit: one word-aligned bus access per request, one-cycle writeback pulse.
module ysyx_23060180_lsu
    import ysyx_23060180_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_23060180_lsu_req_if.slave      req,
    ysyx_23060180_lsu_mem_if.master     mem
);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsu_lat_t          lat_q, lat_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
    logic              wb_err_q, wb_err_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic               al_we;
    logic [FUNC3_W-1:0] al_func3;
    logic [1:0]         al_addr_lo;
    logic [XLEN-1:0]    st_wdata, ld_data;
    logic [MASK_W-1:0]  st_wmask;
    logic               bad;

    // One align unit: fed by the live request in IDLE, by the latched one afterwards.
    assign al_we      = (state_q == ST_IDLE) ? req.req_we          : lat_q.we;
    assign al_func3   = (state_q == ST_IDLE) ? req.req_func3       : lat_q.func3;
    assign al_addr_lo = (state_q == ST_IDLE) ? req.req_addr[1:0]   : lat_q.addr_lo;

    ysyx_23060180_lsu_align u_align (
        .we         (al_we),
        .func3      (al_func3),
        .addr_lo    (al_addr_lo),
        .wdata      (req.req_wdata),
        .rdata      (mem.mem_rdata),
        .st_wdata_c (st_wdata),
        .st_wmask_c (st_wmask),
        .ld_data_c  (ld_data),
        .bad_c      (bad)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        wb_err_d    = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    lat_d.we      = req.req_we;
                    lat_d.func3   = req.req_func3;
                    lat_d.addr_lo = req.req_addr[1:0];
                    lat_d.rd      = req.req_rd;
                    if (bad) begin
                        state_d  = ST_RESP;
                        wb_err_d = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        mem_we_d    = req.req_we;
                        mem_addr_d  = {req.req_addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_wmask_d = st_wmask;
                    end
                end
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    if (lat_q.we) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Data arriving on the timeout cycle still counts as a hit.
                if (mem.mem_rvalid) begin
                    state_d   = ST_RESP;
                    wb_rd_d   = lat_q.rd;
                    wb_data_d = ld_data;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d  = ST_RESP;
                    wb_err_d = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            wb_err_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            wb_err_q    <= wb_err_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign req.wb_valid  = (state_q == ST_RESP);
    assign req.wb_err    = wb_err_q;
    assign req.wb_rd     = wb_rd_q;
    assign req.wb_data   = wb_data_q;
    assign mem.mem_valid = (state_q == ST_REQ);
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Directed + randomized bench for ysyx_23060180_lsu against a word-array memory model.
module tb_ysyx_23060180_lsu;
    import ysyx_23060180_lsu_pkg::*;

    localparam int unsigned TO = 4;
    localparam logic [31:0] BASE = 32'h8000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060180_lsu_req_if rq();
    ysyx_23060180_lsu_mem_if mb();

    ysyx_23060180_lsu #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .mem (mb)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] mem_words [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return off[0];
            3'd2:    return off != 2'b00;
            3'd4:    return we;
            3'd5:    return we | off[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // Load value: take n bytes starting at byte offset, then sign- or zero-extend.
    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        int unsigned n;
        logic [31:0] v, m;
        n = acc_bytes(f3);
        v = word >> (8 * int'(off));
        m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = v & m;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [2:0] f3);
        int unsigned n;
        n = acc_bytes(f3);
        if (n == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    task automatic idle_inputs();
        rq.req_valid  = 1'b0;
        rq.req_we     = 1'b0;
        rq.req_func3  = 3'($urandom);
        rq.req_addr   = $urandom;
        rq.req_wdata  = $urandom;
        rq.req_rd     = 5'($urandom);
        mb.mem_ready  = 1'b0;
        mb.mem_rvalid = 1'b0;
        mb.mem_rdata  = $urandom;
    endtask

    // One full access. rdy_dly = cycles mem_ready stays low; rv_dly = cycles after WAIT entry
    // before rvalid (-1 = never).
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int rdy_dly, input int rv_dly);
        logic bad, eerr, done, saw_mem, ready_hi;
        logic [31:0] edata, ewd, eaddr;
        logic [3:0] emask;
        logic [4:0] erd;
        logic [1:0] off;
        int exp_wb, entry, cyc, acc_cyc, req_cnt, idx;

        off = addr[1:0];
        idx = int'(addr[4:2]);
        bad = exp_bad(we, f3, off);
        eaddr = {addr[31:2], 2'b00};
        ewd = exp_wdata(wdata, f3);
        emask = we ? 4'(((32'd1 << acc_bytes(f3)) - 32'd1) << off) : 4'b0000;
        edata = '0; erd = '0; eerr = 1'b0;
        entry = 2 + rdy_dly;
        if (bad) begin
            exp_wb = 1; eerr = 1'b1;
        end else if (we) begin
            exp_wb = 2 + rdy_dly;
        end else if (rv_dly >= 0 && rv_dly <= int'(TO)) begin
            exp_wb = entry + rv_dly + 1;
            edata = exp_load(mem_words[idx], f3, off);
            erd = rd;
        end else begin
            exp_wb = entry + int'(TO) + 1; eerr = 1'b1;
        end

        chk({tag, " ready_at_issue"}, 32'(rq.req_ready), 32'd1);
        rq.req_valid = 1'b1; rq.req_we = we; rq.req_func3 = f3;
        rq.req_addr = addr; rq.req_wdata = wdata; rq.req_rd = rd;
        step();
        idle_inputs();
        cyc = 1; acc_cyc = -1; req_cnt = 0; done = 1'b0; saw_mem = 1'b0; ready_hi = 1'b0;
        while (!done && cyc < 60) begin
            mb.mem_ready = 1'b0; mb.mem_rvalid = 1'b0; mb.mem_rdata = $urandom;
            if (rq.req_ready) ready_hi = 1'b1;
            if (mb.mem_valid) begin
                saw_mem = 1'b1;
                chk({tag, " mem_addr"}, mb.mem_addr, eaddr);
                chk({tag, " mem_we"}, 32'(mb.mem_we), 32'(we));
                chk({tag, " mem_wmask"}, 32'(mb.mem_wmask), 32'(emask));
                if (we) chk({tag, " mem_wdata"}, mb.mem_wdata, ewd);
                if (req_cnt == rdy_dly) begin
                    mb.mem_ready = 1'b1;
                    acc_cyc = cyc;
                    for (int i = 0; i < 4; i++)
                        if (emask[i]) mem_words[idx][8*i +: 8] = ewd[8*i +: 8];
                end
                req_cnt++;
            end
            if (!we && acc_cyc >= 0 && rv_dly >= 0 && cyc == acc_cyc + 1 + rv_dly) begin
                mb.mem_rvalid = 1'b1;
                mb.mem_rdata = mem_words[idx];
            end
            if (rq.wb_valid) begin
                done = 1'b1;
                chk({tag, " wb_cycle"}, 32'(cyc), 32'(exp_wb));
                chk({tag, " wb_err"}, 32'(rq.wb_err), 32'(eerr));
                chk({tag, " wb_rd"}, 32'(rq.wb_rd), 32'(erd));
                chk({tag, " wb_data"}, rq.wb_data, edata);
            end
            step();
            cyc++;
        end
        idle_inputs();
        chk({tag, " wb_seen"}, 32'(done), 32'd1);
        chk({tag, " ready_low_in_flight"}, 32'(ready_hi), 32'd0);
        if (bad) chk({tag, " no_bus_on_error"}, 32'(saw_mem), 32'd0);
        chk({tag, " pulse_one_cycle"}, 32'(rq.wb_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(rq.req_ready), 32'd1);
    endtask

    initial begin
        logic [2:0] f3s [7];
        logic [2:0] f3;
        logic we;
        int rvd;

        for (int i = 0; i < 8; i++) mem_words[i] = $urandom;
        mem_words[0] = 32'h8899_AABB;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst req_ready", 32'(rq.req_ready), 32'd1);
        chk("rst mem_valid", 32'(mb.mem_valid), 32'd0);
        chk("rst mem_we", 32'(mb.mem_we), 32'd0);
        chk("rst mem_wmask", 32'(mb.mem_wmask), 32'd0);
        chk("rst mem_addr", mb.mem_addr, 32'd0);
        chk("rst mem_wdata", mb.mem_wdata, 32'd0);
        chk("rst wb", {rq.wb_valid, rq.wb_err, 25'(rq.wb_rd)}, 32'd0);
        chk("rst wb_data", rq.wb_data, 32'd0);
        rst = 1'b0;
        step();

        access("LB 0x101", 1'b0, F3_B, BASE + 32'h1, 32'h0, 5'd7, 0, 0);
        access("LHU 0x102", 1'b0, F3_HU, BASE + 32'h2, 32'h0, 5'd9, 0, 0);
        access("LH 0x102", 1'b0, F3_H, BASE + 32'h2, 32'h0, 5'd10, 0, 1);
        access("SB 0x103", 1'b1, F3_B, BASE + 32'h3, 32'h12, 5'd3, 0, 0);
        access("LW after SB", 1'b0, F3_W, BASE, 32'h0, 5'd4, 0, 2);
        access("LW misaligned", 1'b0, F3_W, BASE + 32'h2, 32'h0, 5'd5, 0, 0);
        access("SH misaligned", 1'b1, F3_H, BASE + 32'h5, 32'hBEEF, 5'd5, 0, 0);
        access("SBU illegal", 1'b1, F3_BU, BASE, 32'h1, 5'd5, 0, 0);
        access("LW timeout", 1'b0, F3_W, BASE, 32'h0, 5'd6, 0, -1);
        access("LW rvalid at limit", 1'b0, F3_W, BASE + 32'h4, 32'h0, 5'd8, 1, int'(TO));
        access("SW ready late", 1'b1, F3_W, BASE + 32'h8, 32'hCAFE_F00D, 5'd1, 10, 0);
        access("LHU after SW", 1'b0, F3_HU, BASE + 32'hA, 32'h0, 5'd2, 0, 0);

        // Stray rvalid while idle must not produce anything.
        for (int i = 0; i < 3; i++) begin
            mb.mem_rvalid = 1'b1; mb.mem_rdata = $urandom;
            step();
            chk("stray rvalid wb_valid", 32'(rq.wb_valid), 32'd0);
            chk("stray rvalid ready", 32'(rq.req_ready), 32'd1);
        end
        idle_inputs();

        // Reset while waiting for read data abandons the access.
        rq.req_valid = 1'b1; rq.req_we = 1'b0; rq.req_func3 = F3_W; rq.req_addr = BASE; rq.req_rd = 5'd11;
        step();
        idle_inputs();
        chk("rstwait mem_valid", 32'(mb.mem_valid), 32'd1);
        mb.mem_ready = 1'b1;
        step();
        mb.mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mb.mem_rvalid = 1'b1; mb.mem_rdata = mem_words[0];
        chk("rstwait ready", 32'(rq.req_ready), 32'd1);
        chk("rstwait mem_valid after", 32'(mb.mem_valid), 32'd0);
        chk("rstwait wb_valid", 32'(rq.wb_valid), 32'd0);
        step();
        mb.mem_rvalid = 1'b0;
        chk("rstwait wb_valid late", 32'(rq.wb_valid), 32'd0);
        chk("rstwait ready late", 32'(rq.req_ready), 32'd1);

        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int n = 0; n < 40; n++) begin
            f3 = f3s[$urandom_range(0, 6)];
            we = 1'($urandom);
            rvd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            access("rand", we, f3, BASE + 32'($urandom_range(0, 31)), $urandom,
                   5'($urandom), int'($urandom_range(0, 3)), rvd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_lsu.md
# ysyx_23060180_lsu

Load/store unit that occupies the empty memory stage of the ysyx_23060180 core, directly downstream of the execute stage. It accepts one resolved load/store (address from the ALU result, store data, func3, rd) and performs a single word-aligned access on the data-memory bus. It returns a one-cycle writeback pulse with sign/zero-extended load data, or an error flag for misaligned addresses and memory timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before the access is aborted with error; 8-bit counter, legal range 1–255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2 value).
- req_rd  in  5  load destination register.
- mem_valid  out  1  bus request valid.
- mem_ready  in  1  bus accepts the request this cycle.
- mem_we  out  1  bus write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_wmask  out  4  byte enables; 0000 for loads.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rd  out  5  destination; 0 for stores and errors.
- wb_data  out  32  extended load data; 0 for stores and errors.
- wb_err  out  1  misaligned or timed-out access.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. If req_valid is high, the request is latched into internal registers.
  - Misaligned (H with addr[0]=1, W with addr[1:0]≠0) or illegal func3: go to RESP with err=1; no bus activity.
  - Otherwise go to REQ.
- REQ: mem_valid=1, and mem_we/addr/wdata/wmask are stable from the latched request. On mem_ready, stores go to RESP and loads go to WAIT; otherwise remain in REQ indefinitely.
- WAIT: the timeout counter clears on entry and increments each cycle.
  - On mem_rvalid: latch the extracted data and go to RESP.
  - If the counter reaches TIMEOUT first: go to RESP with err=1.
  - If mem_rvalid and the timeout coincide, the data wins.
- RESP: wb_valid=1 for exactly one cycle, then IDLE.
- Store lane rules:
  - SB: wdata = {4{wdata[7:0]}}, wmask = 1 << addr[1:0].
  - SH: wdata = {2{wdata[15:0]}}, wmask = 0011 << addr[1:0].
  - SW: wmask = 1111.
- Load extract: select the byte or halfword by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
- mem_rvalid outside WAIT is ignored. The memory guarantees rvalid no earlier than the cycle after acceptance.

## Timing
- Reset (rst high at a posedge) takes effect the next cycle:
  - state=IDLE, counter=0.
  - req_ready=1.
  - mem_valid, mem_we, mem_wmask, mem_addr, mem_wdata = 0.
  - wb_valid, wb_err, wb_rd, wb_data = 0.
- Reset mid-operation abandons the access with no writeback pulse. An outstanding rvalid after reset is ignored.
- All outputs are registered or decoded from state only; there is no combinational path from req_* or mem_* to any output.
- Latency (acceptance cycle = 0):
  - Store with mem_ready immediate: mem_valid in cycle 1, wb_valid in cycle 2, req_ready again in cycle 3.
  - Load with mem_ready in cycle 1 and mem_rvalid in cycle 2: wb_valid in cycle 3.
  - Misaligned access: wb_valid with err in cycle 1.
- Throughput: one access in flight. req_ready=0 from cycle 1 until IDLE is re-entered.
- Timeout: wb_err is asserted TIMEOUT+1 cycles after entering WAIT.

## Structure
- Package ysyx_23060180_lsu_pkg:
  - func3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum.
  - Default TIMEOUT constant.
- Sub-module ysyx_23060180_lsu_align (combinational):
  - Store lane shift and mask.
  - Load extract and extend.
  - Misalign detect.
- The top level holds the FSM, request latch, counter and output registers.

## Test plan
- Memory word 0x8899AABB at 0x80000100; LB at 0x80000101, rvalid 1 cycle after accept -> wb_data=0xFFFFFFAA, wb_rd=req_rd, wb_valid in cycle 3.
- LHU at 0x80000102 on the same word -> wb_data=0x00008899; LH at 0x80000102 -> 0xFFFF8899.
- SB at 0x80000103, wdata=0x00000012 -> mem_addr=0x80000100, mem_wmask=1000, mem_wdata=0x12121212; then wb_valid with wb_rd=0.
- LW at 0x80000102 -> wb_err=1 in cycle 1, mem_valid never asserted.
- Load with TIMEOUT=4 and no rvalid -> wb_err=1 exactly 5 cycles after WAIT entry; a later stray rvalid in IDLE has no effect.
- rst during WAIT, then rvalid -> no wb_valid, req_ready=1 the cycle after reset. Also mem_ready held low 10 cycles -> mem_valid and signals stable throughout.
